// File: rtl/hazard_if.sv
// hazard_if: ID-stage hazard bus between the decode stage and the hazard scoreboard.
//   master: drives the ID instruction fields and ex_branch_taken, observes controls
//   slave : the scoreboard; consumes the ID fields, drives stall/flush/debug/perf
interface hazard_if #(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5,
    parameter int CNT_W    = 3
);
    logic                id_valid;
    logic [REG_AW-1:0]   id_rs1;
    logic [REG_AW-1:0]   id_rs2;
    logic                id_use_rs1;
    logic                id_use_rs2;
    logic [REG_AW-1:0]   id_rd;
    logic                id_reg_write;
    logic [CNT_W-1:0]    id_latency;
    logic                ex_branch_taken;
    logic                stall;
    logic                if_id_flush;
    logic                id_ex_flush;
    logic [NUM_REGS-1:0] busy_vec;
    logic [31:0]         stall_cycles;
    logic [31:0]         flush_events;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write,
               id_latency, ex_branch_taken,
        input  stall, if_id_flush, id_ex_flush, busy_vec, stall_cycles, flush_events
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write,
               id_latency, ex_branch_taken,
        output stall, if_id_flush, id_ex_flush, busy_vec, stall_cycles, flush_events
    );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit: per-register writeback scoreboard with branch-flush FSM at ID.
//   clk, rst_n : pipeline clock, asynchronous active-low reset
//   hif (slave): ID instruction fields + ex_branch_taken in; stall, if_id_flush,
//                id_ex_flush, busy_vec, stall_cycles, flush_events out
//   Optional macro HAZARD_PERF_EN builds the saturating stall/flush perf counters;
//   without it both counter ports read 0.
module hazard_scoreboard_unit #(
    parameter int NUM_REGS     = 32,
    parameter int REG_AW       = 5,
    parameter int MAX_LAT      = 7,
    parameter int CNT_W        = 3,
    parameter int FLUSH_CYCLES = 2
) (
    input logic     clk,
    input logic     rst_n,
    hazard_if.slave hif
);
    typedef enum logic {RUN, FLUSH} state_t;

    state_t              state_q, state_d;
    logic [2:0]          fcnt_q, fcnt_d;
    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [CNT_W-1:0]    lat;
    logic                haz, issue, stall, if_id_flush, id_ex_flush;

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) busy[r] = cnt_q[r] != '0;
    end

    assign lat = hif.id_latency > CNT_W'(MAX_LAT) ? CNT_W'(MAX_LAT) : hif.id_latency;

    // rd term is the WAW guard: a younger write must not retire before an older one
    assign haz = hif.id_valid & ((hif.id_use_rs1 & busy[hif.id_rs1]) |
                                 (hif.id_use_rs2 & busy[hif.id_rs2]) |
                                 (hif.id_reg_write & (hif.id_rd != '0) & busy[hif.id_rd]));

    // A taken branch outranks any hazard; the ID instruction is squashed, not issued
    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        stall       = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        issue       = 1'b0;
        if (state_q == FLUSH || hif.ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (hif.ex_branch_taken) begin
                if (FLUSH_CYCLES > 1) begin
                    state_d = FLUSH;
                    fcnt_d  = 3'(FLUSH_CYCLES - 1);
                end
            end else if (fcnt_q <= 3'd1) begin
                state_d = RUN;
                fcnt_d  = '0;
            end else begin
                fcnt_d = fcnt_q - 3'd1;
            end
        end else begin
            stall       = haz;
            id_ex_flush = haz;
            issue       = hif.id_valid & ~haz;
        end
    end

    // Counters keep draining through stalls/flushes; an issuing write overrides the decrement
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++)
            cnt_d[r] = (issue && hif.id_reg_write && hif.id_rd == REG_AW'(r)) ? lat :
                       busy[r] ? cnt_q[r] - CNT_W'(1) : '0;
        cnt_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            fcnt_q  <= '0;
            for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
        end
    end

    // Gated by rst_n so every control output reads 0 while reset is held
    assign hif.stall       = stall & rst_n;
    assign hif.if_id_flush = if_id_flush & rst_n;
    assign hif.id_ex_flush = id_ex_flush & rst_n;
    assign hif.busy_vec    = busy;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d, flush_events_q, flush_events_d;

    assign stall_cycles_d = (stall && stall_cycles_q != '1) ? stall_cycles_q + 32'd1 : stall_cycles_q;
    assign flush_events_d = (hif.ex_branch_taken && flush_events_q != '1) ? flush_events_q + 32'd1
                                                                           : flush_events_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign hif.stall_cycles = stall_cycles_q;
    assign hif.flush_events = flush_events_q;
`else
    assign hif.stall_cycles = '0;
    assign hif.flush_events = '0;
`endif
endmodule
